// File: rtl/reg_array_mp.sv
// Multi-read-port register array with a registered write path, read bypass and a self-timed clear.
// Latency: write lands in the array 2 edges after input; read data is combinational from the registered read address.
// Backpressure: pause holds the write-capture and read-address registers; the clear sequence runs regardless of pause.
module reg_array_mp #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              pause,
  input  logic              clr_req,
  input  logic [NRD-1:0]    rd_clk_cls,
  input  logic              wren,
  input  logic [AW-1:0]     wraddress,
  input  logic [DW-1:0]     data,
  input  logic [NRD*AW-1:0] rdaddress,
  output logic [NRD*DW-1:0] q,
  output logic              busy
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   clr_cnt;
  logic [AW-1:0]   clr_cnt_nxt;

  logic            r_wren;
  logic [AW-1:0]   r_wraddr;
  logic [DW-1:0]   r_data;
  logic [AW-1:0]   r_rdaddr [NRD];

  logic [DW-1:0]   bank [DEPTH];

  // Clear FSM state and counter registers; reset restarts the clear from entry 0.
  always_ff @(posedge clock) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // Next-state logic: one entry cleared per edge, exit after the last entry; the counter wraps to 0 on exit.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      CLEAR: begin
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (&clr_cnt) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt   = IDLE;
        clr_cnt_nxt = '0;
      end
    endcase
  end

  // busy comes straight from the state flop, so it is glitch-free.
  assign busy = (state == CLEAR);

  // Write capture: held by pause, and the enable is forced off while clearing so incoming writes are dropped.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_wren   <= 1'b0;
      r_wraddr <= '0;
      r_data   <= '0;
    end else if (state == CLEAR) begin
      r_wren   <= 1'b0;
    end else if (!pause) begin
      r_wren   <= wren;
      r_wraddr <= wraddress;
      r_data   <= data;
    end
  end

  // Array update: pending commit first, clear write last so a clear of the same entry wins.
  always_ff @(posedge clock) begin
    if (r_wren) begin
      bank[r_wraddr] <= r_data;
    end
    if (!rst && (state == CLEAR)) begin
      bank[clr_cnt] <= '0;
    end
  end

  // Per-port read-address registers, each independently holdable.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NRD; i++) begin
      if (rst) begin
        r_rdaddr[i] <= '0;
      end else if (!pause && !rd_clk_cls[i]) begin
        r_rdaddr[i] <= rdaddress[i*AW +: AW];
      end
    end
  end

  // Read mux per port: clearing forces zero, then the zero register, then bypass of the pending write, then the array.
  always_comb begin
    q = '0;
    for (int i = 0; i < NRD; i++) begin
      if (busy) begin
        q[i*DW +: DW] = '0;
      end else if ((ZERO_REG != 0) && (r_rdaddr[i] == '0)) begin
        q[i*DW +: DW] = '0;
      end else if (r_wren && (r_wraddr == r_rdaddr[i])) begin
        q[i*DW +: DW] = r_data;
      end else begin
        q[i*DW +: DW] = bank[r_rdaddr[i]];
      end
    end
  end

endmodule

// File: tb/tb_reg_array_mp.sv
// Self-checking bench for reg_array_mp: table vectors, hand sequences for clear/reset/hold, and randomized traffic vs a model.
// Latency: model advances once per rising edge; outputs are sampled 1 time unit after the edge.
// Backpressure: pause and rd_clk_cls are exercised both directed and randomly.
module tb_reg_array_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int DEPTH = 32;

  logic              clock;
  logic              rst;
  logic              pause;
  logic              clr_req;
  logic [NRD-1:0]    rd_clk_cls;
  logic              wren;
  logic [AW-1:0]     wraddress;
  logic [DW-1:0]     data;
  logic [AW-1:0]     ra0;
  logic [AW-1:0]     ra1;
  logic [NRD*AW-1:0] rdaddress;
  logic [NRD*DW-1:0] q;
  logic              busy;

  assign rdaddress = {ra1, ra0};

  reg_array_mp #(.DW(DW), .AW(AW), .NRD(NRD), .ZERO_REG(1)) dut (
    .clock      (clock),
    .rst        (rst),
    .pause      (pause),
    .clr_req    (clr_req),
    .rd_clk_cls (rd_clk_cls),
    .wren       (wren),
    .wraddress  (wraddress),
    .data       (data),
    .rdaddress  (rdaddress),
    .q          (q),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Behavioural reference: array contents, the one outstanding captured write,
  // the registered read addresses, and how many clear edges remain.
  logic [DW-1:0] m_mem [DEPTH];
  logic          m_pv;
  logic [AW-1:0] m_pa;
  logic [DW-1:0] m_pd;
  logic [AW-1:0] m_ra [NRD];
  int            m_left;

  typedef struct {
    logic          wr;
    logic [AW-1:0] wa;
    logic [DW-1:0] d;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_q(input int p);
    if (m_left > 0) return '0;
    if (m_ra[p] == 0) return '0;
    if (m_pv && (m_pa == m_ra[p])) return m_pd;
    return m_mem[m_ra[p]];
  endfunction

  task automatic model_step();
    if (m_pv) m_mem[m_pa] = m_pd;
    if (!rst && m_left > 0) m_mem[DEPTH - m_left] = '0;
    for (int i = 0; i < NRD; i++) begin
      if (rst) m_ra[i] = '0;
      else if (!pause && !rd_clk_cls[i]) m_ra[i] = (i == 0) ? ra0 : ra1;
    end
    if (rst) begin
      m_left = DEPTH;
      m_pv = 1'b0; m_pa = '0; m_pd = '0;
    end else if (m_left > 0) begin
      m_left--;
      m_pv = 1'b0;
    end else begin
      if (clr_req) m_left = DEPTH;
      if (!pause) begin
        m_pv = wren; m_pa = wraddress; m_pd = data;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic chk_model(input string nm);
    chk({nm, "_busy"}, 64'(busy), 64'(m_left > 0));
    chk({nm, "_q0"}, 64'(q[DW-1:0]), 64'(model_q(0)));
    chk({nm, "_q1"}, 64'(q[2*DW-1:DW]), 64'(model_q(1)));
  endtask

  // Ticks until busy drops (bounded) and checks it took exactly DEPTH edges.
  task automatic measure_clear(input string nm);
    int k;
    for (k = 1; k <= 40; k++) begin
      tick();
      if (!busy) break;
    end
    chk(nm, 64'(k), 64'(DEPTH));
  endtask

  initial begin
    rst = 1'b0; pause = 1'b0; clr_req = 1'b0; rd_clk_cls = '0;
    wren = 1'b0; wraddress = '0; data = '0; ra0 = '0; ra1 = '0;
    m_pv = 1'b0; m_pa = '0; m_pd = '0; m_left = 0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    for (int i = 0; i < NRD; i++) m_ra[i] = '0;

    vt[0] = '{1'b1, 5'd7, 32'hDEADBEEF, 5'd7, 5'd7, 32'hDEADBEEF, 32'hDEADBEEF};
    vt[1] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd7, 32'hDEADBEEF, 32'hDEADBEEF};
    vt[2] = '{1'b1, 5'd0, 32'h1234,     5'd0, 5'd0, 32'h0,        32'h0};
    vt[3] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd7, 32'h0,        32'hDEADBEEF};
    vt[4] = '{1'b1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd7, 32'hA5A5A5A5, 32'hDEADBEEF};
    vt[5] = '{1'b0, 5'd0, 32'h0,        5'd9, 5'd9, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vt[6] = '{1'b1, 5'd7, 32'h11111111, 5'd7, 5'd9, 32'h11111111, 32'hA5A5A5A5};
    vt[7] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd31, 32'h11111111, 32'h0};

    // Reset pulse, then the power-up clear.
    rst = 1'b1;
    tick();
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_q", 64'(q), 64'd0);
    rst = 1'b0;
    measure_clear("rst_clear_edges");
    for (int a = 0; a < DEPTH; a++) begin
      ra0 = AW'(a); ra1 = AW'(DEPTH - 1 - a);
      tick();
      chk("rst_read_q0", 64'(q[DW-1:0]), 64'd0);
      chk("rst_read_q1", 64'(q[2*DW-1:DW]), 64'd0);
    end

    // Directed write/read/bypass/zero-register vectors.
    for (int i = 0; i < 8; i++) begin
      wren = vt[i].wr; wraddress = vt[i].wa; data = vt[i].d;
      ra0 = vt[i].a0; ra1 = vt[i].a1;
      tick();
      chk($sformatf("vec%0d_q0", i), 64'(q[DW-1:0]), 64'(vt[i].e0));
      chk($sformatf("vec%0d_q1", i), 64'(q[2*DW-1:DW]), 64'(vt[i].e1));
    end

    // pause holds both the write capture and the read address.
    pause = 1'b1; wren = 1'b1; wraddress = 5'd3; data = 32'h55; ra0 = 5'd3;
    repeat (3) tick();
    chk("pause_q0_held", 64'(q[DW-1:0]), 64'h11111111);
    pause = 1'b0; wren = 1'b0;
    tick();
    tick();
    chk("pause_bank3", 64'(q[DW-1:0]), 64'd0);

    // Per-port read-address hold on port 1.
    ra1 = 5'd7;
    tick();
    chk("cls_before", 64'(q[2*DW-1:DW]), 64'h11111111);
    rd_clk_cls = 2'b10; ra1 = 5'd9; ra0 = 5'd9;
    tick();
    tick();
    chk("cls_held_q1", 64'(q[2*DW-1:DW]), 64'h11111111);
    chk("cls_free_q0", 64'(q[DW-1:0]), 64'hA5A5A5A5);
    rd_clk_cls = 2'b00;
    tick();
    chk("cls_release_q1", 64'(q[2*DW-1:DW]), 64'hA5A5A5A5);

    // Fill entries 1..31, then clear with writes attempted throughout.
    for (int a = 1; a < DEPTH; a++) begin
      wren = 1'b1; wraddress = AW'(a); data = 32'h01010101 * a + 32'h100;
      tick();
    end
    wren = 1'b0;
    tick();
    ra0 = 5'd17;
    tick();
    chk("fill_17", 64'(q[DW-1:0]), 64'(32'h01010101 * 17 + 32'h100));
    clr_req = 1'b1;
    tick();
    chk("clr_busy", 64'(busy), 64'd1);
    clr_req = 1'b0; wren = 1'b1; wraddress = 5'd12; data = 32'hBAD0BAD0;
    measure_clear("clr_edges");
    wren = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      ra0 = AW'(a); ra1 = AW'(a);
      tick();
      chk("clr_read_q0", 64'(q[DW-1:0]), 64'd0);
      chk("clr_read_q1", 64'(q[2*DW-1:DW]), 64'd0);
    end

    // Reset in the middle of a clear restarts it from entry 0.
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (15) tick();
    chk("midclr_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    tick();
    chk("midclr_rst_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    measure_clear("midclr_edges");
    chk_model("midclr_end");

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 299) == 0);
      clr_req    = ($urandom_range(0, 99) == 0);
      pause      = ($urandom_range(0, 3) == 0);
      rd_clk_cls = NRD'($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
      wren       = $urandom_range(0, 1) == 1;
      wraddress  = AW'($urandom);
      data       = $urandom;
      ra0        = AW'($urandom);
      ra1        = ($urandom_range(0, 3) == 0) ? ra0 : AW'($urandom);
      tick();
      chk_model("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
